// File: rtl/frv_dmem_responder.sv
// Data-memory bus target: byte-strobed word RAM, address range check and an
// in-order response FIFO whose head is released after a configurable delay.
module frv_dmem_responder #(
  parameter int unsigned MEM_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned LATENCY   = 1,
  parameter int unsigned RSP_DEPTH = 2
) (
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        dmem_req,
  input  logic        dmem_wen,
  input  logic [3:0]  dmem_strb,
  input  logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_addr,
  output logic        dmem_gnt,
  output logic        dmem_recv,
  input  logic        dmem_ack,
  output logic        dmem_error,
  output logic [31:0] dmem_rdata
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int PW = $clog2(RSP_DEPTH);
  localparam int DW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [31:0]   MEM_BYTES = 32'(MEM_WORDS * 4);
  localparam logic [DW-1:0] DLY_LOAD  = DW'(LATENCY - 1);
  localparam logic [PW:0]   DEPTH     = (PW + 1)'(RSP_DEPTH);

  logic [31:0]          r_mem [MEM_WORDS];
  logic [31:0]          r_q_data [RSP_DEPTH];
  logic [RSP_DEPTH-1:0] r_q_err;
  logic [PW-1:0]        r_wptr;
  logic [PW-1:0]        r_rptr;
  logic [PW:0]          r_count;
  logic [DW-1:0]        r_delay;

  logic [31:0]   w_offset;
  logic          w_in_range;
  logic [AW-1:0] w_index;
  logic          w_head_valid;
  logic          w_accept;
  logic          w_deq;
  logic          w_new_head;

  // Unsigned subtraction folds addresses below BASE_ADDR into the out-of-range case.
  assign w_offset     = dmem_addr - BASE_ADDR;
  assign w_in_range   = w_offset < MEM_BYTES;
  assign w_index      = w_offset[AW+1:2];

  assign w_head_valid = r_count != '0;
  assign dmem_gnt     = !g_reset && (r_count < DEPTH);
  assign dmem_recv    = w_head_valid && (r_delay == '0);
  assign w_accept     = dmem_req && dmem_gnt;
  assign w_deq        = dmem_recv && dmem_ack;
  assign dmem_rdata   = dmem_recv ? r_q_data[r_rptr] : '0;
  assign dmem_error   = dmem_recv && r_q_err[r_rptr];

  // A fresh entry reaches the head when the queue was empty, or when the head
  // leaves while another entry is queued or arriving on the same edge.
  assign w_new_head   = (w_accept && !w_head_valid) ||
                        (w_deq && ((r_count > (PW + 1)'(1)) || w_accept));

  always_ff @(posedge g_clk) begin
    if (w_accept && dmem_wen && w_in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (dmem_strb[i]) r_mem[w_index][i*8 +: 8] <= dmem_wdata[i*8 +: 8];
      end
    end
  end

  // Response payload storage is not reset; validity comes from r_count alone.
  always_ff @(posedge g_clk) begin
    if (w_accept) begin
      r_q_data[r_wptr] <= (w_in_range && !dmem_wen) ? r_mem[w_index] : '0;
      r_q_err[r_wptr]  <= !w_in_range;
    end
  end

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_delay <= '0;
    end else begin
      if (w_accept) r_wptr <= r_wptr + 1'b1;
      if (w_deq)    r_rptr <= r_rptr + 1'b1;
      case ({w_accept, w_deq})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_new_head) begin
        r_delay <= DLY_LOAD;
      end else if (w_head_valid && (r_delay != '0)) begin
        r_delay <= r_delay - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_frv_dmem_responder.sv
// Self-checking bench: instance "dut" (LATENCY=1) is checked against a
// scoreboard fed by a memory model; instance "dut3" (LATENCY=3) for timing.
module tb_frv_dmem_responder;

  localparam logic [31:0] MEM_BYTES = 32'h0000_1000;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } rsp_t;

  typedef struct packed {
    logic        w;
    logic [31:0] a;
    logic [3:0]  s;
    logic [31:0] d;
  } req_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req = 1'b0, wen = 1'b0, ack = 1'b0;
  logic [3:0]  strb = 4'h0;
  logic [31:0] wdata = '0, addr = '0;
  logic        gnt, recv, err;
  logic [31:0] rdata;

  logic        req3 = 1'b0, wen3 = 1'b0, ack3 = 1'b0;
  logic [3:0]  strb3 = 4'h0;
  logic [31:0] wdata3 = '0, addr3 = '0;
  logic        gnt3, recv3, err3;
  logic [31:0] rdata3;

  int          checks = 0;
  int          errors = 0;
  rsp_t        sbq[$];
  logic [31:0] mdl[int];

  always #5 clk = ~clk;

  frv_dmem_responder #(.MEM_WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(1), .RSP_DEPTH(2)) dut (
    .g_clk(clk), .g_reset(rst), .dmem_req(req), .dmem_wen(wen), .dmem_strb(strb),
    .dmem_wdata(wdata), .dmem_addr(addr), .dmem_gnt(gnt), .dmem_recv(recv),
    .dmem_ack(ack), .dmem_error(err), .dmem_rdata(rdata)
  );

  frv_dmem_responder #(.MEM_WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(3), .RSP_DEPTH(2)) dut3 (
    .g_clk(clk), .g_reset(rst), .dmem_req(req3), .dmem_wen(wen3), .dmem_strb(strb3),
    .dmem_wdata(wdata3), .dmem_addr(addr3), .dmem_gnt(gnt3), .dmem_recv(recv3),
    .dmem_ack(ack3), .dmem_error(err3), .dmem_rdata(rdata3)
  );

  // Drive one request on dut from a negedge, wait (bounded) for the grant, and
  // push the model's expected response once it is accepted. Returns at a negedge.
  task automatic send(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    bit   ok = 1'b0;
    rsp_t e;
    int   idx;
    req = 1'b1; wen = w; addr = a; strb = s; wdata = d;
    for (int t = 0; t < 20 && !ok; t++) begin
      if (gnt === 1'b1) ok = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    req = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_grant addr=%h gnt=%b required 1 within 20 cycles", a, gnt);
    end else begin
      e.err  = !(a < MEM_BYTES);
      e.data = '0;
      if (!e.err) begin
        idx = int'(a[11:2]);
        if (w) begin
          if (!mdl.exists(idx)) mdl[idx] = '0;
          for (int i = 0; i < 4; i++)
            if (s[i]) mdl[idx][i*8 +: 8] = d[i*8 +: 8];
        end else begin
          e.data = mdl[idx];
        end
      end
      sbq.push_back(e);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #2;
    checks++;
    if (gnt !== 1'b0 || recv !== 1'b0 || gnt3 !== 1'b0 || recv3 !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold gnt=%b recv=%b gnt3=%b recv3=%b required all 0", gnt, recv, gnt3, recv3);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (gnt !== 1'b1 || recv !== 1'b0 || err !== 1'b0 || rdata !== 32'h0 || gnt3 !== 1'b1 || recv3 !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle gnt=%b recv=%b err=%b rdata=%h gnt3=%b recv3=%b required 1 0 0 0 1 0",
               gnt, recv, err, rdata, gnt3, recv3);
    end
  endtask

  task automatic test_strobe;
    req_t tbl[7] = '{
      '{1'b1, 32'h00, 4'hF, 32'h1111_1111},
      '{1'b1, 32'h04, 4'hF, 32'h2222_2222},
      '{1'b1, 32'h08, 4'hF, 32'h3333_3333},
      '{1'b1, 32'h10, 4'hF, 32'hAABB_CCDD},
      '{1'b1, 32'h10, 4'h2, 32'h0000_1100},
      '{1'b1, 32'h04, 4'h0, 32'hFFFF_FFFF},
      '{1'b0, 32'h10, 4'h0, 32'h0}
    };
    rsp_t e;
    for (int i = 0; i < 7; i++) begin
      send(tbl[i].w, tbl[i].a, tbl[i].s, tbl[i].d);
      checks++;
      if (recv !== 1'b1) begin
        errors++;
        $display("FAIL strobe_latency item=%0d recv=%b required 1", i, recv);
      end else if (sbq.size() != 0) begin
        e = sbq.pop_front();
        checks++;
        if (err !== e.err || rdata !== e.data) begin
          errors++;
          $display("FAIL strobe_rsp item=%0d err=%b rdata=%h required err=%b rdata=%h", i, err, rdata, e.err, e.data);
        end
      end
      ack = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ack = 1'b0;
      checks++;
      if (recv !== 1'b0) begin
        errors++;
        $display("FAIL strobe_dequeue item=%0d recv=%b required 0", i, recv);
      end
    end
  endtask

  task automatic test_out_of_range;
    req_t tbl[4] = '{
      '{1'b0, 32'h0000_1000, 4'h0, 32'h0},
      '{1'b1, 32'hFFFF_FFFC, 4'hF, 32'hDEAD_BEEF},
      '{1'b1, 32'h0000_1004, 4'hF, 32'h5555_5555},
      '{1'b0, 32'h0000_0000, 4'h0, 32'h0}
    };
    rsp_t e;
    for (int i = 0; i < 4; i++) begin
      send(tbl[i].w, tbl[i].a, tbl[i].s, tbl[i].d);
      checks++;
      if (recv !== 1'b1) begin
        errors++;
        $display("FAIL oor_latency item=%0d recv=%b required 1", i, recv);
      end else if (sbq.size() != 0) begin
        e = sbq.pop_front();
        checks++;
        if (err !== e.err || rdata !== e.data) begin
          errors++;
          $display("FAIL oor_rsp item=%0d err=%b rdata=%h required err=%b rdata=%h", i, err, rdata, e.err, e.data);
        end
      end
      ack = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ack = 1'b0;
    end
  endtask

  task automatic test_backpressure;
    rsp_t e;
    int   t;
    ack = 1'b0;
    send(1'b0, 32'h0, 4'h0, 32'h0);
    send(1'b0, 32'h4, 4'h0, 32'h0);
    req = 1'b1; wen = 1'b0; addr = 32'h8;
    checks++;
    if (gnt !== 1'b0) begin
      errors++;
      $display("FAIL bp_gnt_full gnt=%b required 0", gnt);
    end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (recv !== 1'b1 || err !== 1'b0 || rdata !== mdl[0] || gnt !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cycle=%0d recv=%b err=%b rdata=%h gnt=%b required 1 0 %h 0",
                 k, recv, err, rdata, gnt, mdl[0]);
      end
      @(posedge clk);
      @(negedge clk);
    end
    e = sbq.pop_front();
    checks++;
    if (err !== e.err || rdata !== e.data) begin
      errors++;
      $display("FAIL bp_head err=%b rdata=%h required err=%b rdata=%h", err, rdata, e.err, e.data);
    end
    ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ack = 1'b0;
    checks++;
    if (gnt !== 1'b1) begin
      errors++;
      $display("FAIL bp_gnt_reopen gnt=%b required 1", gnt);
    end
    @(posedge clk);
    sbq.push_back('{1'b0, mdl[2]});
    @(negedge clk);
    req = 1'b0;
    for (int k = 0; k < 2; k++) begin
      t = 0;
      while (recv !== 1'b1 && t < 20) begin
        @(negedge clk);
        t++;
      end
      checks++;
      if (recv !== 1'b1) begin
        errors++;
        $display("FAIL bp_drain_timeout item=%0d recv=%b required 1", k, recv);
      end else begin
        e = sbq.pop_front();
        checks++;
        if (err !== e.err || rdata !== e.data) begin
          errors++;
          $display("FAIL bp_order item=%0d err=%b rdata=%h required err=%b rdata=%h", k, err, rdata, e.err, e.data);
        end
        ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ack = 1'b0;
      end
    end
  endtask

  task automatic test_latency;
    logic [31:0] wd[2] = '{32'h5A5A_5A5A, 32'h0F0F_0F0F};
    int t;
    for (int i = 0; i < 2; i++) begin
      req3 = 1'b1; wen3 = 1'b1; strb3 = 4'hF; addr3 = 32'(i * 4); wdata3 = wd[i];
      @(posedge clk);
      @(negedge clk);
      req3 = 1'b0; wen3 = 1'b0;
      t = 0;
      while (recv3 !== 1'b1 && t < 10) begin
        @(negedge clk);
        t++;
      end
      checks++;
      if (recv3 !== 1'b1 || err3 !== 1'b0 || t != 2) begin
        errors++;
        $display("FAIL lat3_write item=%0d recv3=%b err3=%b wait=%0d required 1 0 2", i, recv3, err3, t);
      end
      ack3 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ack3 = 1'b0;
    end
    // single read: recv must first appear two edges after the accept edge
    req3 = 1'b1; addr3 = 32'h0;
    @(posedge clk);
    @(negedge clk);
    req3 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (recv3 !== 1'b0) begin
        errors++;
        $display("FAIL lat3_early cycle=%0d recv3=%b required 0", k, recv3);
      end
      @(posedge clk);
      @(negedge clk);
    end
    checks++;
    if (recv3 !== 1'b1 || rdata3 !== wd[0] || err3 !== 1'b0) begin
      errors++;
      $display("FAIL lat3_single recv3=%b rdata3=%h err3=%b required 1 %h 0", recv3, rdata3, err3, wd[0]);
    end
    ack3 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ack3 = 1'b0;
    // two queued reads: second head waits a full LATENCY after the first ack
    req3 = 1'b1; addr3 = 32'h0;
    @(posedge clk);
    @(negedge clk);
    addr3 = 32'h4;
    @(posedge clk);
    @(negedge clk);
    req3 = 1'b0;
    checks++;
    if (recv3 !== 1'b0) begin
      errors++;
      $display("FAIL lat3_q_early recv3=%b required 0", recv3);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (recv3 !== 1'b1 || rdata3 !== wd[0]) begin
      errors++;
      $display("FAIL lat3_q_first recv3=%b rdata3=%h required 1 %h", recv3, rdata3, wd[0]);
    end
    ack3 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ack3 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (recv3 !== 1'b0) begin
        errors++;
        $display("FAIL lat3_q_gap cycle=%0d recv3=%b required 0", k, recv3);
      end
      @(posedge clk);
      @(negedge clk);
    end
    checks++;
    if (recv3 !== 1'b1 || rdata3 !== wd[1]) begin
      errors++;
      $display("FAIL lat3_q_second recv3=%b rdata3=%h required 1 %h", recv3, rdata3, wd[1]);
    end
    ack3 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ack3 = 1'b0;
  endtask

  task automatic test_reset_mid;
    rsp_t e;
    ack = 1'b0;
    send(1'b1, 32'h20, 4'hF, 32'hCAFE_F00D);
    send(1'b0, 32'h0, 4'h0, 32'h0);
    checks++;
    if (recv !== 1'b1 || gnt !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_pre recv=%b gnt=%b required 1 0", recv, gnt);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (recv !== 1'b0 || gnt !== 1'b0 || rdata !== 32'h0) begin
      errors++;
      $display("FAIL rstmid_async recv=%b gnt=%b rdata=%h required 0 0 0", recv, gnt, rdata);
    end
    sbq.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (recv !== 1'b0 || gnt !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_release recv=%b gnt=%b required 0 1", recv, gnt);
    end
    @(negedge clk);
    send(1'b0, 32'h20, 4'h0, 32'h0);
    checks++;
    if (recv !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_read recv=%b required 1", recv);
    end else begin
      e = sbq.pop_front();
      checks++;
      if (err !== e.err || rdata !== e.data) begin
        errors++;
        $display("FAIL rstmid_data err=%b rdata=%h required err=%b rdata=%h", err, rdata, e.err, e.data);
      end
    end
    ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_strobe();
    test_out_of_range();
    test_backpressure();
    test_latency();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
